ram_cmd_arbiter: RTL and testbench
==================================

# ram_cmd_arbiter

Shares the single-port RAM's 10-bit command port between two requesters: the SPI slave path (requester 0) and a local host/DMA path (requester 1). Each requester issues whole read or write transactions over a valid/ready handshake. The arbiter expands each transaction into the RAM's two-command sequence (address, then data or read), waits for read data, and returns a one-cycle response to the owner. Arbitration is round-robin, and transactions are atomic: commands from the two requesters never interleave.

## Interface
- ADDR_WIDTH, 8, RAM address width (command low byte).
- DATA_WIDTH, 8, RAM data width.
- TIMEOUT, 4, max WAIT cycles for ram_tx_valid before error response (≥2).

- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  reset, synchronous, active-low.
- reqN_valid  in  1  (N=0,1) transaction request; held until accepted.
- reqN_ready  out  1  accept strobe; transfer when valid&ready.
- reqN_we  in  1  1=write, 0=read.
- reqN_addr  in  ADDR_WIDTH  RAM address.
- reqN_wdata  in  DATA_WIDTH  write data (ignored for reads).
- rspN_valid  out  1  one-cycle completion pulse to requester N.
- rspN_rdata  out  DATA_WIDTH  read data; 0 for writes or on error.
- rspN_err  out  1  read timed out.
- ram_din  out  ADDR_WIDTH+2  command to RAM: {op[1:0], payload}.
- ram_rx_valid  out  1  command strobe to RAM.
- ram_tx_valid  in  1  RAM read-data valid.
- ram_dout  in  DATA_WIDTH  RAM read data.
- busy  out  1  high in any state other than IDLE.
- owner  out  1  id of current/last granted requester.

## Operation
- Command opcodes: 00 = write address, 01 = write data, 10 = read address, 11 = read.
- The arbiter holds a round-robin pointer rr: 0 prefers req0, 1 prefers req1.

**FSM states:** IDLE, ADDR, DATA, WAIT, RESP.
- **IDLE**
  - If any reqN_valid: grant per rr (the sole requester if only one is valid).
  - reqN_ready is high combinationally for the granted requester only.
  - Capture we, addr, wdata and owner, then go to ADDR.
  - reqN_ready is 0 in every state except IDLE.
- **ADDR**
  - ram_rx_valid=1.
  - ram_din = {we?2'b00:2'b10, addr}.
  - Next state: DATA.
- **DATA**
  - ram_rx_valid=1.
  - ram_din = we ? {2'b01, wdata} : {2'b11, 8'h00}.
  - Next state: RESP for a write, WAIT for a read. Clear the timeout counter.
- **WAIT**
  - ram_rx_valid=0.
  - If ram_tx_valid: capture ram_dout and go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 with no ram_tx_valid: go to RESP with err=1 and rdata=0.
  - The read-address command clears RAM tx_valid, so tx_valid seen high in WAIT is always fresh data.
- **RESP**
  - rspN_valid=1 for the owner only, with rdata and err.
  - rr <= ~owner.
  - Next state: IDLE.
- Responses have no backpressure; the requester must accept rsp in the pulse cycle.
- ram_din = 0 whenever ram_rx_valid = 0.
- ram_din, ram_rx_valid and all rsp outputs are driven from registers, with no combinational path from req inputs. reqN_ready is the only combinational output.

## Timing
**Reset** (rstn=0 at an edge):
- State: IDLE. rr=0. owner=0. Counter=0.
- Outputs: ram_rx_valid=0, ram_din=0, rsp*_valid=0, rsp*_rdata=0, rsp*_err=0, busy=0.
- Reset during any state aborts the transaction: no response is issued and commands stop on the next cycle.

**Latency** (accept in cycle T):
- Address command in T+1, data/read command in T+2.
- Write: rsp in T+3.
- Read: the RAM registers dout at the end of T+2, so tx_valid is high in T+3 (WAIT), and rsp comes in T+4.
- Timeout: rsp in T+2+TIMEOUT.

**Throughput:**
- One transaction per 4 cycles (write) or 5 cycles (read), including the mandatory IDLE cycle.

**Arbitration edge cases:**
- Simultaneous valids: exactly one is granted, by rr. The loser stays pending and is granted in the next IDLE because rr flips.
- A single persistent requester is served back-to-back regardless of rr.
- A request that arrives mid-transaction waits for IDLE. Its inputs are sampled only at the grant cycle.

## Test plan
1. **Write, req0.** After reset, req0 write addr=0x12 wdata=0xA5 -> ready in T; ram_din 0x012 at T+1 and 0x1A5 at T+2 with rx_valid high; rsp0_valid at T+3 with rdata=0, err=0.
2. **Read, req1.** req1 read addr=0x12 against the RAM model -> ram_din 0x212 then 0x300; rsp1_valid at T+4 with rdata=0xA5; rsp0_valid stays 0.
3. **Round-robin.** Both valid continuously after reset, writes to 0x01 (req0) and 0x02 (req1) -> grant order 0,1,0,1; commands never interleave; each response goes only to its owner.
4. **Timeout.** Force ram_tx_valid=0 with TIMEOUT=4 and issue a read -> rsp_valid at T+6 with err=1 and rdata=0x00; FSM returns to IDLE.
5. **Reset mid-transaction.** Assert rstn=0 during DATA -> next cycle ram_rx_valid=0, no rsp pulse, busy=0, rr=0; a following req1-only read completes normally.
6. **Back-to-back single requester.** req0 issues 3 writes to 0x10, 0x11, 0x12 -> accepts at T, T+4, T+8; RAM contents verified by later reads.

Source files
------------

// File: rtl/ram_cmd_arbiter.sv
// ram_cmd_arbiter: shares the RAM command port between two requesters.
// Each accepted transaction becomes an address command followed by a data
// or read command. Reads then wait, with a timeout, for RAM read data, and
// every transaction ends with a one-cycle response to its owner.
//
// Handshake: a request transfers in the cycle where reqN_valid & reqN_ready
// are both high. reqN_ready is asserted only in IDLE, only for the granted
// requester, and it is the sole combinational output. rspN_* is a one-cycle
// pulse with no backpressure.
module ram_cmd_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int TIMEOUT    = 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic                  req0_we,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_wdata,
   output logic                  rsp0_valid,
   output logic [DATA_WIDTH-1:0] rsp0_rdata,
   output logic                  rsp0_err,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic                  req1_we,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_wdata,
   output logic                  rsp1_valid,
   output logic [DATA_WIDTH-1:0] rsp1_rdata,
   output logic                  rsp1_err,
   output logic [ADDR_WIDTH+1:0] ram_din,
   output logic                  ram_rx_valid,
   input  logic                  ram_tx_valid,
   input  logic [DATA_WIDTH-1:0] ram_dout,
   output logic                  busy,
   output logic                  owner,
   output logic [2:0]            state_dbg
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 2);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ADDR = 3'd1,
      S_DATA = 3'd2,
      S_WAIT = 3'd3,
      S_RESP = 3'd4
   } state_t;

   state_t                state, state_n;
   logic                  rr, rr_n;
   logic                  owner_q, owner_n;
   logic                  we_q, we_n;
   logic [ADDR_WIDTH-1:0] addr_q, addr_n;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_n;
   logic [CW-1:0]         cnt, cnt_n;

   logic [ADDR_WIDTH+1:0] din_n;
   logic                  rxv_n;
   logic                  rsp_fire_n;
   logic [DATA_WIDTH-1:0] rsp_rd_n;
   logic                  rsp_err_n;

   logic                  any_req;
   logic                  grant;

   // Round-robin pick: rr breaks ties, a lone requester always wins.
   always_comb begin
      any_req    = req0_valid | req1_valid;
      grant      = (req0_valid & req1_valid) ? rr : req1_valid;
      req0_ready = (state == S_IDLE) & req0_valid & ~grant;
      req1_ready = (state == S_IDLE) & req1_valid & grant;
   end

   // Next-state, captured transaction fields and next registered outputs.
   always_comb begin
      state_n    = state;
      rr_n       = rr;
      owner_n    = owner_q;
      we_n       = we_q;
      addr_n     = addr_q;
      wdata_n    = wdata_q;
      cnt_n      = cnt;
      din_n      = '0;
      rxv_n      = 1'b0;
      rsp_fire_n = 1'b0;
      rsp_rd_n   = '0;
      rsp_err_n  = 1'b0;
      case (state)
         S_IDLE: begin
            if (any_req) begin
               owner_n = grant;
               we_n    = grant ? req1_we    : req0_we;
               addr_n  = grant ? req1_addr  : req0_addr;
               wdata_n = grant ? req1_wdata : req0_wdata;
               rxv_n   = 1'b1;
               din_n   = {(we_n ? 2'b00 : 2'b10), addr_n};
               state_n = S_ADDR;
            end
         end
         S_ADDR: begin
            rxv_n   = 1'b1;
            din_n   = we_q ? {2'b01, ADDR_WIDTH'(wdata_q)} : {2'b11, {ADDR_WIDTH{1'b0}}};
            state_n = S_DATA;
         end
         S_DATA: begin
            cnt_n = '0;
            if (we_q) begin
               rsp_fire_n = 1'b1;
               state_n    = S_RESP;
            end else begin
               state_n = S_WAIT;
            end
         end
         S_WAIT: begin
            if (ram_tx_valid) begin
               rsp_fire_n = 1'b1;
               rsp_rd_n   = ram_dout;
               state_n    = S_RESP;
            end else if (cnt == CNT_LAST) begin
               rsp_fire_n = 1'b1;
               rsp_err_n  = 1'b1;
               state_n    = S_RESP;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         S_RESP: begin
            rr_n    = ~owner_q;
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // State, transaction fields and all registered outputs; reset aborts.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state        <= S_IDLE;
         rr           <= 1'b0;
         owner_q      <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         cnt          <= '0;
         ram_din      <= '0;
         ram_rx_valid <= 1'b0;
         rsp0_valid   <= 1'b0;
         rsp0_rdata   <= '0;
         rsp0_err     <= 1'b0;
         rsp1_valid   <= 1'b0;
         rsp1_rdata   <= '0;
         rsp1_err     <= 1'b0;
      end else begin
         state        <= state_n;
         rr           <= rr_n;
         owner_q      <= owner_n;
         we_q         <= we_n;
         addr_q       <= addr_n;
         wdata_q      <= wdata_n;
         cnt          <= cnt_n;
         ram_din      <= din_n;
         ram_rx_valid <= rxv_n;
         rsp0_valid   <= rsp_fire_n & ~owner_q;
         rsp0_rdata   <= (rsp_fire_n & ~owner_q) ? rsp_rd_n : '0;
         rsp0_err     <= rsp_fire_n & ~owner_q & rsp_err_n;
         rsp1_valid   <= rsp_fire_n & owner_q;
         rsp1_rdata   <= (rsp_fire_n & owner_q) ? rsp_rd_n : '0;
         rsp1_err     <= rsp_fire_n & owner_q & rsp_err_n;
      end
   end

   // Status taps derived directly from registers.
   always_comb begin
      busy      = (state != S_IDLE);
      owner     = owner_q;
      state_dbg = state;
   end

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Bench for ram_cmd_arbiter: directed vector table, hand-written corner
// sequences (round-robin, timeout, reset abort, back-to-back) and a random
// phase checked against a transaction-level model (memory array + rr bit).
module tb_ram_cmd_arbiter;
   localparam int TIMEOUT = 4;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       rv[2];
   logic       rwe[2];
   logic [7:0] raddr[2];
   logic [7:0] rwd[2];
   logic       rdy0, rdy1, rspv0, rspv1, rspe0, rspe1;
   logic [7:0] rspd0, rspd1;
   logic [9:0] ram_din;
   logic       ram_rx_valid, ram_tx_valid;
   logic [7:0] ram_dout;
   logic       busy, owner;
   logic [2:0] state_dbg;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int acc_cyc = 0;

   // RAM environment model
   logic [7:0] ram_mem[256];
   logic [7:0] ram_a = 8'h00;
   logic [7:0] ram_q = 8'h00;
   logic       ram_txv = 1'b0;
   logic       force_no_tx = 1'b0;

   // Transaction-level reference model
   logic [7:0] ref_mem[256];
   logic       rr_m = 1'b0;

   typedef struct {
      int         id;
      bit         we;
      logic [7:0] addr;
      logic [7:0] wd;
      logic [7:0] exp_rd;
      bit         exp_err;
   } vec_t;
   vec_t tbl[8];

   ram_cmd_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rstn(rstn),
      .req0_valid(rv[0]), .req0_ready(rdy0), .req0_we(rwe[0]),
      .req0_addr(raddr[0]), .req0_wdata(rwd[0]),
      .rsp0_valid(rspv0), .rsp0_rdata(rspd0), .rsp0_err(rspe0),
      .req1_valid(rv[1]), .req1_ready(rdy1), .req1_we(rwe[1]),
      .req1_addr(raddr[1]), .req1_wdata(rwd[1]),
      .rsp1_valid(rspv1), .rsp1_rdata(rspd1), .rsp1_err(rspe1),
      .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
      .ram_tx_valid(ram_tx_valid), .ram_dout(ram_dout),
      .busy(busy), .owner(owner), .state_dbg(state_dbg)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // RAM: decode {op, payload}; read-address clears tx_valid, read sets it
   always @(posedge clk) begin
      if (ram_rx_valid) begin
         case (ram_din[9:8])
            2'b00: ram_a <= ram_din[7:0];
            2'b01: ram_mem[ram_a] <= ram_din[7:0];
            2'b10: begin ram_a <= ram_din[7:0]; ram_txv <= 1'b0; end
            default: begin ram_q <= ram_mem[ram_a]; ram_txv <= 1'b1; end
         endcase
      end
   end
   assign ram_tx_valid = ram_txv & ~force_no_tx;
   assign ram_dout     = ram_q;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic get_rdy(input int id);
      return id ? rdy1 : rdy0;
   endfunction
   function automatic logic get_rspv(input int id);
      return id ? rspv1 : rspv0;
   endfunction
   function automatic logic [7:0] get_rspd(input int id);
      return id ? rspd1 : rspd0;
   endfunction
   function automatic logic get_rspe(input int id);
      return id ? rspe1 : rspe0;
   endfunction

   task automatic set_req(input int id, input logic v, input logic we,
                          input logic [7:0] a, input logic [7:0] d);
      rv[id] = v; rwe[id] = we; raddr[id] = a; rwd[id] = d;
   endtask

   // Called at an IDLE-cycle negedge with requester id's inputs applied.
   task automatic do_txn(input int id, input bit we, input logic [7:0] addr,
                         input logic [7:0] wd, input logic [7:0] exp_rd,
                         input bit exp_err, input bit keep);
      int lat;
      #1;
      chk("grant_ready", get_rdy(id), 1'b1);
      chk("other_ready", get_rdy(1 - id), 1'b0);
      acc_cyc = cyc;
      @(negedge clk);
      chk("addr_rxv", ram_rx_valid, 1'b1);
      chk("addr_cmd", ram_din, {(we ? 2'b00 : 2'b10), addr});
      chk("owner", owner, id[0]);
      chk("ready_busy", rdy0 | rdy1, 1'b0);
      if (!keep) rv[id] = 1'b0;
      @(negedge clk);
      chk("data_rxv", ram_rx_valid, 1'b1);
      chk("data_cmd", ram_din, we ? {2'b01, wd} : 10'h300);
      lat = we ? 1 : (exp_err ? TIMEOUT : 2);
      for (int k = 1; k < lat; k++) begin
         @(negedge clk);
         chk("wait_rsp", rspv0 | rspv1, 1'b0);
         chk("wait_rxv", {ram_rx_valid, ram_din}, 11'h0);
      end
      @(negedge clk);
      chk("rsp_valid", get_rspv(id), 1'b1);
      chk("rsp_other", get_rspv(1 - id), 1'b0);
      chk("rsp_rdata", get_rspd(id), exp_rd);
      chk("rsp_err", get_rspe(id), exp_err);
      chk("rsp_rxv", ram_rx_valid, 1'b0);
      @(negedge clk);
      chk("idle_busy", busy, 1'b0);
      chk("idle_rsp", rspv0 | rspv1, 1'b0);
      rr_m = ~id[0];
      if (we) ref_mem[addr] = wd;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      rv[0] = 1'b0; rv[1] = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_rxv", ram_rx_valid, 1'b0);
      chk("rst_din", ram_din, 10'h0);
      chk("rst_rsp", {rspv0, rspv1, rspe0, rspe1, rspd0, rspd1}, 20'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_owner", owner, 1'b0);
      rstn = 1'b1;
      rr_m = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int v, g, t0;
      logic [7:0] a, d, e;
      bit w;
      for (int i = 0; i < 256; i++) begin
         ram_mem[i] = 8'h00;
         ref_mem[i] = 8'h00;
      end
      for (int i = 0; i < 2; i++) set_req(i, 1'b0, 1'b0, 8'h00, 8'h00);

      tbl[0] = '{0, 1'b1, 8'h12, 8'hA5, 8'h00, 1'b0};
      tbl[1] = '{1, 1'b0, 8'h12, 8'h00, 8'hA5, 1'b0};
      tbl[2] = '{1, 1'b1, 8'h34, 8'hC3, 8'h00, 1'b0};
      tbl[3] = '{0, 1'b0, 8'h34, 8'h00, 8'hC3, 1'b0};
      tbl[4] = '{0, 1'b1, 8'hFF, 8'h5E, 8'h00, 1'b0};
      tbl[5] = '{1, 1'b0, 8'hFF, 8'h00, 8'h5E, 1'b0};
      tbl[6] = '{0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
      tbl[7] = '{1, 1'b1, 8'h00, 8'h81, 8'h00, 1'b0};

      do_reset();

      // directed vector table
      for (int i = 0; i < 8; i++) begin
         set_req(tbl[i].id, 1'b1, tbl[i].we, tbl[i].addr, tbl[i].wd);
         do_txn(tbl[i].id, tbl[i].we, tbl[i].addr, tbl[i].wd,
                tbl[i].exp_rd, tbl[i].exp_err, 1'b0);
      end

      // round-robin with both requesters held valid
      do_reset();
      set_req(0, 1'b1, 1'b1, 8'h01, 8'hB0);
      set_req(1, 1'b1, 1'b1, 8'h02, 8'hB1);
      do_txn(0, 1'b1, 8'h01, 8'hB0, 8'h00, 1'b0, 1'b1);
      do_txn(1, 1'b1, 8'h02, 8'hB1, 8'h00, 1'b0, 1'b1);
      do_txn(0, 1'b1, 8'h01, 8'hB0, 8'h00, 1'b0, 1'b1);
      do_txn(1, 1'b1, 8'h02, 8'hB1, 8'h00, 1'b0, 1'b0);
      rv[0] = 1'b0;

      // timeout: RAM never returns data
      force_no_tx = 1'b1;
      set_req(1, 1'b1, 1'b0, 8'h12, 8'h00);
      do_txn(1, 1'b0, 8'h12, 8'h00, 8'h00, 1'b1, 1'b0);
      chk("timeout_idle", state_dbg, 3'd0);
      force_no_tx = 1'b0;

      // reset during DATA of a read, after rr has moved to 1
      set_req(0, 1'b1, 1'b1, 8'h20, 8'h5A);
      do_txn(0, 1'b1, 8'h20, 8'h5A, 8'h00, 1'b0, 1'b0);
      set_req(0, 1'b1, 1'b0, 8'h20, 8'h00);
      #1 chk("abort_ready", rdy0, 1'b1);
      @(negedge clk);
      rv[0] = 1'b0;
      @(negedge clk);
      chk("abort_data", ram_din, 10'h300);
      rstn = 1'b0;
      @(negedge clk);
      chk("abort_rxv", ram_rx_valid, 1'b0);
      chk("abort_rsp", rspv0 | rspv1, 1'b0);
      chk("abort_busy", busy, 1'b0);
      rstn = 1'b1;
      rr_m = 1'b0;
      @(negedge clk);
      chk("abort_norsp", rspv0 | rspv1, 1'b0);
      set_req(0, 1'b1, 1'b1, 8'h21, 8'h66);
      set_req(1, 1'b1, 1'b0, 8'h20, 8'h00);
      do_txn(0, 1'b1, 8'h21, 8'h66, 8'h00, 1'b0, 1'b0);
      do_txn(1, 1'b0, 8'h20, 8'h00, 8'h5A, 1'b0, 1'b0);

      // back-to-back single requester
      set_req(0, 1'b1, 1'b1, 8'h10, 8'h71);
      do_txn(0, 1'b1, 8'h10, 8'h71, 8'h00, 1'b0, 1'b1);
      t0 = acc_cyc;
      set_req(0, 1'b1, 1'b1, 8'h11, 8'h72);
      do_txn(0, 1'b1, 8'h11, 8'h72, 8'h00, 1'b0, 1'b1);
      chk("b2b_second", acc_cyc - t0, 4);
      set_req(0, 1'b1, 1'b1, 8'h12, 8'h73);
      do_txn(0, 1'b1, 8'h12, 8'h73, 8'h00, 1'b0, 1'b0);
      chk("b2b_third", acc_cyc - t0, 8);
      for (int i = 0; i < 3; i++) begin
         a = 8'h10 + 8'(i);
         e = 8'h71 + 8'(i);
         set_req(1, 1'b1, 1'b0, a, 8'h00);
         do_txn(1, 1'b0, a, 8'h00, e, 1'b0, 1'b0);
      end

      // random traffic against the transaction-level model
      for (int n = 0; n < 60; n++) begin
         v = $urandom_range(1, 3);
         for (int i = 0; i < 2; i++)
            set_req(i, v[i], 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
                    8'($urandom_range(0, 255)));
         g = (v == 3) ? int'(rr_m) : ((v == 2) ? 1 : 0);
         w = rwe[g];
         a = raddr[g];
         d = rwd[g];
         e = w ? 8'h00 : ref_mem[a];
         do_txn(g, w, a, d, e, 1'b0, 1'b0);
         rv[0] = 1'b0; rv[1] = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
